// File: rtl/fetch_unit.sv
// Instruction fetch stage: streams words from instruction memory into a single
// registered slot with a valid/ready handoff, taking branch/jump redirects.
module fetch_unit #(
  parameter logic [31:0] PROG_LENGTH = 32'd22,
  parameter logic [31:0] RESET_PC    = 32'd0
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] PC,
  input  logic [31:0] Instruction,
  output logic [31:0] ir_out,
  output logic [31:0] ir_pc,
  output logic        ir_valid,
  input  logic        ir_ready,
  input  logic        redirect_valid,
  input  logic        redirect_kind,
  input  logic [31:0] redirect_base,
  input  logic [25:0] redirect_imm,
  output logic [1:0]  opclass,
  output logic [15:0] fetch_count,
  output logic        halted
);

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]  state;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] redirect_target;
  logic        handoff;
  logic        slot_free;
  logic        pc_in_range;

  // Branch offsets are relative to the instruction after the branch; the sum
  // wraps modulo 2^32 and a wrapped target simply lands beyond the program.
  assign branch_target   = redirect_base + 32'd1
                         + {{16{redirect_imm[15]}}, redirect_imm[15:0]};
  assign jump_target     = {6'd0, redirect_imm};
  assign redirect_target = redirect_kind ? jump_target : branch_target;

  assign handoff     = ir_valid && ir_ready;
  assign slot_free   = !ir_valid || ir_ready;
  assign pc_in_range = (PC <= PROG_LENGTH);

  assign opclass = ir_out[31:30];
  assign halted  = (state == ST_DONE) && !ir_valid;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register here samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= ST_FETCH;
      PC          <= RESET_PC;
      ir_out      <= 32'd0;
      ir_pc       <= 32'd0;
      ir_valid    <= 1'b0;
      fetch_count <= 16'd0;
    end else if (redirect_valid) begin
      // A redirect discards the slot contents, including any handoff this cycle.
      ir_valid <= 1'b0;
      PC       <= redirect_target;
      state    <= (redirect_target > PROG_LENGTH) ? ST_DONE : ST_FETCH;
    end else begin
      if (handoff && (fetch_count != 16'hFFFF)) begin
        fetch_count <= fetch_count + 16'd1;
      end

      case (state)
        ST_FETCH, ST_WAIT: begin
          if (slot_free) begin
            if (pc_in_range) begin
              ir_out   <= Instruction;
              ir_pc    <= PC;
              ir_valid <= 1'b1;
              PC       <= PC + 32'd1;
              state    <= ST_FETCH;
            end else begin
              // Slot is free here, so any held instruction was just accepted.
              ir_valid <= 1'b0;
              state    <= ST_DONE;
            end
          end else begin
            state <= ST_WAIT;
          end
        end
        ST_DONE: begin
          if (handoff) begin
            ir_valid <= 1'b0;
          end
        end
        default: begin
          state <= ST_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, stall, redirects, end-of-program,
// wrapped branch target and reset overriding a redirect.
module tb_fetch_unit;

  logic        clk;
  logic        reset_n;
  logic [31:0] PC;
  logic [31:0] Instruction;
  logic [31:0] ir_out;
  logic [31:0] ir_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic        redirect_valid;
  logic        redirect_kind;
  logic [31:0] redirect_base;
  logic [25:0] redirect_imm;
  logic [1:0]  opclass;
  logic [15:0] fetch_count;
  logic        halted;

  int checks   = 0;
  int failures = 0;

  fetch_unit #(.PROG_LENGTH(32'd22), .RESET_PC(32'd0)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .PC             (PC),
    .Instruction    (Instruction),
    .ir_out         (ir_out),
    .ir_pc          (ir_pc),
    .ir_valid       (ir_valid),
    .ir_ready       (ir_ready),
    .redirect_valid (redirect_valid),
    .redirect_kind  (redirect_kind),
    .redirect_base  (redirect_base),
    .redirect_imm   (redirect_imm),
    .opclass        (opclass),
    .fetch_count    (fetch_count),
    .halted         (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: top two bits follow the address so opclass varies.
  function automatic logic [31:0] imem(input logic [31:0] a);
    return {a[1:0], 14'h1ABC, a[15:0]};
  endfunction

  assign Instruction = imem(PC);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_slot(input string tag, input logic [31:0] exp_ir_pc,
                            input logic [31:0] exp_pc, input logic [15:0] exp_cnt);
    check({tag, ".ir_valid"}, {31'd0, ir_valid}, 32'd1);
    check({tag, ".ir_pc"}, ir_pc, exp_ir_pc);
    check({tag, ".ir_out"}, ir_out, imem(exp_ir_pc));
    check({tag, ".opclass"}, {30'd0, opclass}, {30'd0, exp_ir_pc[1:0]});
    check({tag, ".PC"}, PC, exp_pc);
    check({tag, ".count"}, {16'd0, fetch_count}, {16'd0, exp_cnt});
    check({tag, ".halted"}, {31'd0, halted}, 32'd0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".PC"}, PC, 32'd0);
    check({tag, ".ir_out"}, ir_out, 32'd0);
    check({tag, ".ir_pc"}, ir_pc, 32'd0);
    check({tag, ".ir_valid"}, {31'd0, ir_valid}, 32'd0);
    check({tag, ".count"}, {16'd0, fetch_count}, 32'd0);
    check({tag, ".halted"}, {31'd0, halted}, 32'd0);
  endtask

  task automatic redirect(input logic kind, input logic [31:0] base, input logic [25:0] imm);
    redirect_valid = 1'b1;
    redirect_kind  = kind;
    redirect_base  = base;
    redirect_imm   = imm;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    reset_n        = 1'b0;
    ir_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_kind  = 1'b0;
    redirect_base  = 32'd0;
    redirect_imm   = 26'd0;
    step();
    step();
    check_reset("reset");

    // Streaming from reset: one fetch per cycle, count lags by one handoff.
    reset_n = 1'b1;
    step();
    check_slot("first", 32'd0, 32'd1, 16'd0);
    for (int i = 1; i <= 4; i++) begin
      step();
      check_slot($sformatf("stream%0d", i), i, i + 1, 16'(i));
    end

    // Stall with ir_pc=4: everything holds for three cycles.
    ir_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_slot($sformatf("stall%0d", i), 32'd4, 32'd5, 16'd4);
    end
    ir_ready = 1'b1;
    step();
    check_slot("unstall", 32'd5, 32'd6, 16'd5);
    step();
    step();
    check_slot("pc7", 32'd7, 32'd8, 16'd7);

    // Branch back: 12 + 1 - 3 = 10; handoff in the redirect cycle not counted.
    redirect(1'b0, 32'd12, 26'h3FFFD);
    check("br.ir_valid", {31'd0, ir_valid}, 32'd0);
    check("br.PC", PC, 32'd10);
    check("br.count", {16'd0, fetch_count}, 32'd7);
    step();
    check_slot("br_first", 32'd10, 32'd11, 16'd7);

    // Jump to 21 and run off the end of the program with a stall on 22.
    redirect(1'b1, 32'd0, 26'd21);
    check("jmp.ir_valid", {31'd0, ir_valid}, 32'd0);
    check("jmp.PC", PC, 32'd21);
    step();
    check_slot("jmp21", 32'd21, 32'd22, 16'd7);
    step();
    check_slot("jmp22", 32'd22, 32'd23, 16'd8);
    ir_ready = 1'b0;
    step();
    step();
    check_slot("last_stall", 32'd22, 32'd23, 16'd8);
    ir_ready = 1'b1;
    step();
    check("end.ir_valid", {31'd0, ir_valid}, 32'd0);
    check("end.halted", {31'd0, halted}, 32'd1);
    check("end.PC", PC, 32'd23);
    check("end.count", {16'd0, fetch_count}, 32'd9);
    step();
    check("end_hold.halted", {31'd0, halted}, 32'd1);
    check("end_hold.PC", PC, 32'd23);

    // Wrapped branch target 0 + 1 - 5 = 0xFFFFFFFC goes straight to DONE.
    redirect(1'b0, 32'd0, 26'h0FFFB);
    check("wrap.halted", {31'd0, halted}, 32'd1);
    check("wrap.ir_valid", {31'd0, ir_valid}, 32'd0);
    check("wrap.PC", PC, 32'hFFFF_FFFC);
    step();
    check("wrap_hold.PC", PC, 32'hFFFF_FFFC);
    check("wrap_hold.halted", {31'd0, halted}, 32'd1);

    // A jump leaves DONE.
    redirect(1'b1, 32'd0, 26'd3);
    check("rejmp.halted", {31'd0, halted}, 32'd0);
    check("rejmp.ir_valid", {31'd0, ir_valid}, 32'd0);
    check("rejmp.PC", PC, 32'd3);
    step();
    check_slot("rejmp3", 32'd3, 32'd4, 16'd9);
    for (int i = 4; i <= 7; i++) begin
      step();
      check_slot($sformatf("run%0d", i), i, i + 1, 16'(i + 6));
    end

    // Reset wins over a simultaneous redirect.
    reset_n        = 1'b0;
    redirect_valid = 1'b1;
    redirect_kind  = 1'b1;
    redirect_imm   = 26'd15;
    step();
    check_reset("rst_redirect");
    reset_n        = 1'b0;
    redirect_valid = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    check_slot("post_reset", 32'd0, 32'd1, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
